// File: rtl/frame_streamer_pkg.sv
// Shared constants for the frame streamer: default geometry, tag-bit layout
// and FSM state encodings.
package frame_streamer_pkg;

  localparam int PX_WIDTH_DEF  = 160;
  localparam int PX_HEIGHT_DEF = 120;
  localparam int PIX_BITS_DEF  = 3;

  localparam int TAG_W   = 3;
  localparam int TAG_SOF = 0;
  localparam int TAG_EOL = 1;
  localparam int TAG_EOF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } fs_state_e;

endpackage

// File: rtl/frame_streamer_if.sv
// Pixel-memory read port plus the valid/ready pixel stream with frame markers.
interface frame_streamer_if #(
  parameter int ADDR_W   = 16,
  parameter int PIX_BITS = 3
);
  logic [ADDR_W-1:0]   mem_addr;
  logic [PIX_BITS-1:0] mem_data;
  logic                out_valid;
  logic                out_ready;
  logic [PIX_BITS-1:0] out_data;
  logic                out_sof;
  logic                out_eol;
  logic                out_eof;

  modport master (
    output mem_addr, input mem_data,
    output out_valid, output out_data, output out_sof, output out_eol, output out_eof,
    input  out_ready
  );

  modport slave (
    input  mem_addr, output mem_data,
    input  out_valid, input out_data, input out_sof, input out_eol, input out_eof,
    output out_ready
  );
endinterface

// File: rtl/frame_streamer_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide at full.
module fs_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);
  localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_pop_s, do_push_s;

  assign do_pop_s  = pop_i && (count_q != '0);
  assign do_push_s = push_i && ((count_q != FULL_C) || do_pop_s);

  // Entry storage; needs no reset because reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/frame_streamer.sv
// Raster-order frame scanner: reads pixel memory with credit-based flow
// control and streams codes with sof/eol/eof markers.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int PX_WIDTH   = PX_WIDTH_DEF,
  parameter int PX_HEIGHT  = PX_HEIGHT_DEF,
  parameter int PIX_BITS   = PIX_BITS_DEF,
  parameter int ADDR_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int META_W     = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              frame_req,
  input  logic [META_W-1:0] meta_in,
  input  logic              flag_in,
  frame_streamer_if.master  fs,
  output logic [META_W-1:0] meta_out,
  output logic              flag_out,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        drop_cnt
);
  localparam int X_W   = $clog2(PX_WIDTH);
  localparam int Y_W   = $clog2(PX_HEIGHT);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_W-1:0]   X_LAST  = X_W'(PX_WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(PX_HEIGHT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  fs_state_e         state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [META_W-1:0] meta_q, meta_d;
  logic              flag_q, flag_d, busy_q, busy_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic [RD_LAT-1:0] vld_q;
  logic [TAG_W-1:0]  tag_q [RD_LAT];
  logic [TAG_W-1:0]  tag_s;
  logic [CNT_W-1:0]  inflight_s, fifo_count_s;
  logic              issue_s, last_x_s, last_y_s, fifo_empty_s, pop_s;
  logic [PIX_BITS+TAG_W-1:0] head_s;

  assign last_x_s = (x_q == X_LAST);
  assign last_y_s = (y_q == Y_LAST);
  assign pop_s    = !fifo_empty_s && fs.out_ready;

  // Reads in flight = occupied slots of the latency pipeline.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < RD_LAT; i++) inflight_s = inflight_s + CNT_W'(vld_q[i]);
  end

  // Issue only when the FIFO is guaranteed room for every outstanding read.
  assign issue_s = (state_q == SCAN) && ((fifo_count_s + inflight_s) < DEPTH_C);

  // Marker tag for the pixel being issued.
  always_comb begin
    tag_s          = '0;
    tag_s[TAG_SOF] = (x_q == '0) && (y_q == '0);
    tag_s[TAG_EOL] = last_x_s;
    tag_s[TAG_EOF] = last_x_s && last_y_s;
  end

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    meta_d      = meta_q;
    flag_d      = flag_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (frame_req) begin
          meta_d  = meta_in;
          flag_d  = flag_in;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (issue_s) begin
          if (last_x_s) begin
            x_d = '0;
            if (last_y_s) state_d = DRAIN;
            else          y_d = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
          // Address parks on the final pixel rather than running past the frame.
          if (last_x_s && last_y_s) addr_d = addr_q;
          else                      addr_d = addr_q + ADDR_W'(1);
        end else begin
          state_d = SCAN;
        end
      end
      DRAIN: begin
        if ((inflight_s == '0) && fifo_empty_s) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_req && (state_q != IDLE) && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    else                                                          drop_cnt_d = drop_cnt_q;
  end

  // State and control registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      meta_q      <= '0;
      flag_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      meta_q      <= meta_d;
      flag_q      <= flag_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Tag/valid pipeline matched to the memory read latency.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= issue_s;
      tag_q[0] <= tag_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  fs_fifo #(.WIDTH(PIX_BITS + TAG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push_i    (vld_q[RD_LAT-1]),
    .wr_data_i ({tag_q[RD_LAT-1], fs.mem_data}),
    .pop_i     (pop_s),
    .rd_data_o (head_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_count_s)
  );

  assign fs.mem_addr  = addr_q;
  assign fs.out_valid = !fifo_empty_s;
  assign fs.out_data  = head_s[PIX_BITS-1:0];
  assign fs.out_sof   = head_s[PIX_BITS+TAG_SOF];
  assign fs.out_eol   = head_s[PIX_BITS+TAG_EOL];
  assign fs.out_eof   = head_s[PIX_BITS+TAG_EOF];
  assign meta_out     = meta_q;
  assign flag_out     = flag_q;
  assign busy         = busy_q;
  assign frame_cnt    = frame_cnt_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Synthesizable frame-scan engine. It walks the renderer's second read port (pixel-code memory) in raster order and streams pixel codes out on a valid/ready interface with start-of-frame, end-of-line and end-of-frame markers.
- Generalises the per-frame pixel dump: parametrised geometry, pixel width and memory read latency; backpressure-safe; frame counting and dropped-request accounting.
- Sits between the renderer's read port and any consumer (UART/debug dump, second display path, simulation monitor). Triggered once per render tick.

Parameters:
- PX_WIDTH, 160, pixels per line (>=2)
- PX_HEIGHT, 120, lines per frame (>=2)
- PIX_BITS, 3, bits per pixel code
- ADDR_W, 16, memory address width; must satisfy PX_WIDTH*PX_HEIGHT <= 2**ADDR_W
- RD_LAT, 1, memory read latency in cycles, from address to data (1..4)
- FIFO_DEPTH, 4, output buffer entries, power of two, >= RD_LAT+1
- META_W, 16, width of per-frame metadata word (score)

Ports:
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-low
- frame_req  in  1  single-cycle pulse requesting a frame scan (already synchronised to clk)
- meta_in  in  META_W  score value, captured at frame start
- flag_in  in  1  perfect flag, captured at frame start
- mem_addr  out  ADDR_W  pixel-memory read address
- mem_data  in  PIX_BITS  pixel-memory read data, valid RD_LAT cycles after mem_addr
- out_valid  out  1  pixel available
- out_ready  in  1  consumer accepts pixel
- out_data  out  PIX_BITS  pixel code
- out_sof  out  1  qualifies pixel (0,0)
- out_eol  out  1  qualifies last pixel of each line
- out_eof  out  1  qualifies last pixel of frame
- meta_out  out  META_W  metadata latched for the current/last frame
- flag_out  out  1  flag latched for the current/last frame
- busy  out  1  scan or drain in progress
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0
- drop_cnt  out  8  ignored frame_req pulses, saturates at 255

Behaviour:
- Reset (clr=0, asynchronous): state IDLE. All outputs are 0, including mem_addr, the counters and meta_out. FIFO and the in-flight pipeline are emptied. A reset mid-frame abandons the frame; no partial marker is emitted afterwards.
- FSM has three states: IDLE, SCAN, DRAIN.
- IDLE: on frame_req=1, latch meta_in/flag_in into meta_out/flag_out, clear x/y/addr, set busy=1, go to SCAN. Otherwise hold.
- SCAN: read-issue rule, checked each cycle:
  - A read is issued when credits = FIFO_DEPTH - fifo_count - inflight > 0.
  - On issue, mem_addr = y*PX_WIDTH + x. The address is kept incrementally (+1 per issue); no multiplier.
  - A tag {sof,eol,eof} travels through an RD_LAT-deep shift register alongside the read. The returning data plus tag is written into the FIFO.
  - x wraps at PX_WIDTH-1, at which point y increments. Issuing pixel (PX_WIDTH-1, PX_HEIGHT-1) moves the FSM to DRAIN.
- DRAIN: no new reads. When inflight=0, FIFO is empty, and the final pop has occurred: frame_cnt+1, busy=0, go to IDLE.
- Output handshake:
  - out_valid = FIFO not empty; out_data and the markers come from the FIFO head.
  - A pop happens when out_valid & out_ready.
  - While out_valid=1 & out_ready=0, all output fields stay stable.
  - No combinational path from out_ready to out_valid.
- Latency: with out_ready=1, a frame_req sampled at edge k gives the first read issued in cycle k+1 and out_valid=1 in cycle k+1+RD_LAT+1.
- Throughput: 1 pixel/cycle when out_ready=1. Frame duration is PX_WIDTH*PX_HEIGHT + RD_LAT + 2 cycles.
- frame_req while busy=1 (SCAN or DRAIN, including the completion cycle): ignored; drop_cnt+1, saturating at 255. No queueing.
- Markers:
  - out_sof=1 only on pixel 0.
  - out_eol=1 on x=PX_WIDTH-1.
  - out_eof=1 only on the final pixel, together with eol.
- meta_out/flag_out hold their value until the next accepted frame_req.

Decomposition:
- Shared constants file (alongside the existing consts): PX_WIDTH/PX_HEIGHT defaults, PIX_BITS, the tag-bit positions, and the state encodings IDLE=2'd0, SCAN=2'd1, DRAIN=2'd2.
- One natural sub-module: fs_fifo. It is a synchronous FIFO of width PIX_BITS+3 and depth FIFO_DEPTH, exposes count, and supports simultaneous push/pop at full (pop frees space the same cycle).

Test Plan (PX_WIDTH=4, PX_HEIGHT=3, RD_LAT=2, FIFO_DEPTH=4; memory model returns mem[a]=a%8 after 2 cycles):
- Single frame, out_ready=1: pulse frame_req at cycle 10 -> out_valid first at cycle 14; 12 pixels 0,1,...,7,0,1,2,3; sof on pixel 0, eol on pixels 3/7/11, eof on pixel 11; frame_cnt=1; busy=0.
- Backpressure: out_ready toggled 1-of-3 cycles -> identical 12-pixel sequence, no duplicates or losses; out_data stable during stalls; inflight+fifo_count never exceeds 4.
- Metadata: meta_in=0x0123, flag_in=1 at the request, then changed to 0x0456 mid-frame -> meta_out stays 0x0123 and flag_out stays 1 until the next frame.
- Dropped requests: 3 frame_req pulses during SCAN plus 1 in the completion cycle -> drop_cnt=4; 300 pulses while busy -> drop_cnt=255.
- Reset mid-frame: clr=0 after pixel 5 -> all outputs 0 asynchronously; after release, a new frame_req yields a clean 12-pixel frame starting with sof; frame_cnt=1.
- Wrap: preload frame_cnt near 0xFFFF (or run 65536 frames with 2x2 geometry) -> frame_cnt rolls over to 0.
